// File: rtl/dest_arbiter.sv
// ============================================================================
// dest_arbiter : per-output round-robin destination arbiter with packet locks
// Revision 1.0
// ============================================================================
`default_nettype none

module dest_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DEST_W    = 2
) (
   input  logic                        clock_i,
   input  logic                        reset_n_i,
   input  logic [NUM_PORTS-1:0]        req_i,
   input  logic [NUM_PORTS*DEST_W-1:0] dest_i,
   input  logic [NUM_PORTS-1:0]        out_ready_i,
   output logic [NUM_PORTS-1:0]        grant_o,
   output logic [NUM_PORTS-1:0]        out_busy_o,
   output logic [NUM_PORTS*DEST_W-1:0] out_sel_o,
   output logic [NUM_PORTS-1:0]        unique_o
);

   localparam int              N           = NUM_PORTS;
   localparam logic [DEST_W:0] NUM_PORTS_W = (DEST_W+1)'(NUM_PORTS);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_e;

   state_e            state_q [N];
   state_e            state_d [N];
   logic [DEST_W-1:0] owner_q [N];
   logic [DEST_W-1:0] owner_d [N];
   logic [DEST_W-1:0] ptr_q   [N];
   logic [DEST_W-1:0] ptr_d   [N];
   logic [N-1:0]      grant_q, grant_d;
   logic [N-1:0]      unique_q, unique_d;

   logic [DEST_W-1:0] dest_w  [N];
   logic [N-1:0]      dest_ok;
   logic [N-1:0]      eligible;
   logic [N-1:0]      arb_en;
   logic [DEST_W-1:0] arb_base [N];

   // (base + off) mod N, valid because base < N and off < N
   function automatic logic [DEST_W-1:0] wrap_add(input logic [DEST_W-1:0] base,
                                                  input logic [DEST_W:0]   off);
      logic [DEST_W:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= NUM_PORTS_W) begin
         sum = sum - NUM_PORTS_W;
      end
      return sum[DEST_W-1:0];
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_port
         assign dest_w[gi]   = dest_i[gi*DEST_W +: DEST_W];
         assign dest_ok[gi]  = ({1'b0, dest_w[gi]} < NUM_PORTS_W);
         // An input already holding a lock may not compete for another output.
         assign eligible[gi] = req_i[gi] & ~grant_q[gi];
         assign out_busy_o[gi]                  = (state_q[gi] == S_LOCKED);
         assign out_sel_o[gi*DEST_W +: DEST_W]  = owner_q[gi];
      end
   endgenerate

   assign grant_o  = grant_q;
   assign unique_o = unique_q;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         unique_d[i] = req_i[i] & dest_ok[i];
         for (int j = 0; j < N; j++) begin
            if ((j != i) && req_i[j] && (dest_w[j] == dest_w[i])) begin
               unique_d[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin : p_release
      for (int d = 0; d < N; d++) begin
         arb_en[d]   = (state_q[d] == S_IDLE);
         arb_base[d] = ptr_q[d];
         ptr_d[d]    = ptr_q[d];
         // Release and re-arbitrate on the same edge from the advanced pointer.
         if ((state_q[d] == S_LOCKED) && !req_i[owner_q[d]]) begin
            arb_en[d]   = 1'b1;
            ptr_d[d]    = wrap_add(owner_q[d], (DEST_W+1)'(1));
            arb_base[d] = wrap_add(owner_q[d], (DEST_W+1)'(1));
         end
      end
   end

   always_comb begin : p_arb
      logic [DEST_W-1:0] idx;
      logic              found;
      grant_d = grant_q;
      idx     = '0;
      found   = 1'b0;
      for (int d = 0; d < N; d++) begin
         state_d[d] = state_q[d];
         owner_d[d] = owner_q[d];
         if (arb_en[d] && (state_q[d] == S_LOCKED)) begin
            state_d[d]           = S_IDLE;
            owner_d[d]           = '0;
            grant_d[owner_q[d]]  = 1'b0;
         end
      end
      for (int d = 0; d < N; d++) begin
         found = 1'b0;
         if (arb_en[d] && out_ready_i[d]) begin
            for (int k = 0; k < N; k++) begin
               idx = wrap_add(arb_base[d], (DEST_W+1)'(k));
               if (!found && eligible[idx] && (dest_w[idx] == DEST_W'(d))) begin
                  found        = 1'b1;
                  state_d[d]   = S_LOCKED;
                  owner_d[d]   = idx;
                  grant_d[idx] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int d = 0; d < N; d++) begin
            state_q[d] <= S_IDLE;
            owner_q[d] <= '0;
            ptr_q[d]   <= '0;
         end
         grant_q  <= '0;
         unique_q <= '0;
      end else begin
         for (int d = 0; d < N; d++) begin
            state_q[d] <= state_d[d];
            owner_q[d] <= owner_d[d];
            ptr_q[d]   <= ptr_d[d];
         end
         grant_q  <= grant_d;
         unique_q <= unique_d;
      end
   end

endmodule

`default_nettype wire
